// File: rtl/icache_mem_bridge_pkg.sv
// Shared types and width helpers for the instruction-cache to instruction-memory bridge.
// Line-side bus widths are all derived from the number of 32-bit words per line.
package icache_mem_bridge_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StBusy = 2'd1,
        StDone = 2'd2
    } state_e;

    function automatic int unsigned cache_mem_addr_bus(input int unsigned addr_w,
                                                       input int unsigned line_words);
        return addr_w - $clog2(line_words) - 2;
    endfunction

    function automatic int unsigned cache_mem_byte_bus(input int unsigned line_words);
        return 4 * line_words;
    endfunction

    function automatic int unsigned cache_mem_data_bus(input int unsigned line_words);
        return 32 * line_words;
    endfunction

endpackage

// File: rtl/icache_mem_bridge_if.sv
// Cache-side line command port: one line read/write command in, one assembled line back.
// The master modport is the cache, the slave modport is the bridge.
interface icache_mem_bridge_if #(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned LINE_WORDS = 4
) ();

    localparam int unsigned LINE_AW = icache_mem_bridge_pkg::cache_mem_addr_bus(ADDR_W, LINE_WORDS);
    localparam int unsigned BYTE_W  = icache_mem_bridge_pkg::cache_mem_byte_bus(LINE_WORDS);
    localparam int unsigned DATA_W  = icache_mem_bridge_pkg::cache_mem_data_bus(LINE_WORDS);

    logic [LINE_AW-1:0] i_m_addr;
    logic [BYTE_W-1:0]  i_m_byte_en;
    logic [DATA_W-1:0]  i_m_writedata;
    logic               i_m_read;
    logic               i_m_write;
    logic [DATA_W-1:0]  o_m_readdata;
    logic               o_m_readdata_valid;
    logic               o_m_waitrequest;

    modport master (
        output i_m_addr, i_m_byte_en, i_m_writedata, i_m_read, i_m_write,
        input  o_m_readdata, o_m_readdata_valid, o_m_waitrequest
    );

    modport slave (
        input  i_m_addr, i_m_byte_en, i_m_writedata, i_m_read, i_m_write,
        output o_m_readdata, o_m_readdata_valid, o_m_waitrequest
    );

endinterface

// File: rtl/icache_mem_bridge.sv
// Splits one cache-line command into LINE_WORDS word transactions on a req/gnt/rvalid bus,
// collects the in-order responses and returns the line with a one-cycle valid pulse.
module icache_mem_bridge
    import icache_mem_bridge_pkg::*;
#(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned LINE_WORDS = 4,
    parameter int unsigned LINE_AW    = cache_mem_addr_bus(ADDR_W, LINE_WORDS)
) (
    input  logic                clk,
    input  logic                rst_n,
    icache_mem_bridge_if.slave  cache,
    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [3:0]          mem_be,
    output logic [31:0]         mem_wdata,
    input  logic                mem_gnt,
    input  logic                mem_rvalid,
    input  logic [31:0]         mem_rdata
);

    localparam int unsigned IdxW  = $clog2(LINE_WORDS);
    localparam int unsigned CntW  = IdxW + 1;
    localparam int unsigned ByteW = cache_mem_byte_bus(LINE_WORDS);
    localparam int unsigned DataW = cache_mem_data_bus(LINE_WORDS);

    typedef logic [CntW-1:0] cnt_t;
    localparam cnt_t LineCnt = cnt_t'(LINE_WORDS);
    localparam cnt_t LastCnt = cnt_t'(LINE_WORDS - 1);

    state_e             state_q, state_d;
    cnt_t               iss_cnt_q, iss_cnt_d;
    cnt_t               rsp_cnt_q, rsp_cnt_d;
    logic [LINE_AW-1:0] line_addr_q, line_addr_d;
    logic [ByteW-1:0]   be_q, be_d;
    logic [DataW-1:0]   wdata_q, wdata_d;
    logic               op_write_q, op_write_d;
    logic [DataW-1:0]   buf_q, buf_d;

    logic [IdxW-1:0]    iss_idx;
    logic [IdxW-1:0]    rsp_idx;
    logic               rsp_take;

    assign iss_idx = iss_cnt_q[IdxW-1:0];
    assign rsp_idx = rsp_cnt_q[IdxW-1:0];
    // Only responses to requests already granted count; anything else is a stray.
    assign rsp_take = mem_rvalid && (rsp_cnt_q < iss_cnt_q);

    assign cache.o_m_waitrequest    = (state_q != StIdle);
    assign cache.o_m_readdata_valid = (state_q == StDone) && !op_write_q;
    assign cache.o_m_readdata       = buf_q;

    always_comb begin
        state_d     = state_q;
        iss_cnt_d   = iss_cnt_q;
        rsp_cnt_d   = rsp_cnt_q;
        line_addr_d = line_addr_q;
        be_d        = be_q;
        wdata_d     = wdata_q;
        op_write_d  = op_write_q;
        buf_d       = buf_q;
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        mem_addr    = '0;
        mem_be      = '0;
        mem_wdata   = '0;

        unique case (state_q)
            StIdle: begin
                if (cache.i_m_read || cache.i_m_write) begin
                    line_addr_d = cache.i_m_addr;
                    be_d        = cache.i_m_byte_en;
                    wdata_d     = cache.i_m_writedata;
                    op_write_d  = !cache.i_m_read;
                    state_d     = StBusy;
                end
            end
            StBusy: begin
                if (iss_cnt_q < LineCnt) begin
                    mem_req   = 1'b1;
                    mem_we    = op_write_q;
                    mem_addr  = {line_addr_q, iss_idx, 2'b00};
                    mem_be    = be_q[{iss_idx, 2'b00} +: 4];
                    mem_wdata = wdata_q[{iss_idx, 5'b00000} +: 32];
                    if (mem_gnt) begin
                        iss_cnt_d = iss_cnt_q + cnt_t'(1);
                    end
                end
                if (rsp_take) begin
                    if (!op_write_q) begin
                        buf_d[{rsp_idx, 5'b00000} +: 32] = mem_rdata;
                    end
                    rsp_cnt_d = rsp_cnt_q + cnt_t'(1);
                    if (rsp_cnt_q == LastCnt) begin
                        state_d = StDone;
                    end
                end
            end
            StDone: begin
                iss_cnt_d = '0;
                rsp_cnt_d = '0;
                state_d   = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            iss_cnt_q   <= '0;
            rsp_cnt_q   <= '0;
            line_addr_q <= '0;
            be_q        <= '0;
            wdata_q     <= '0;
            op_write_q  <= 1'b0;
            buf_q       <= '0;
        end else begin
            state_q     <= state_d;
            iss_cnt_q   <= iss_cnt_d;
            rsp_cnt_q   <= rsp_cnt_d;
            line_addr_q <= line_addr_d;
            be_q        <= be_d;
            wdata_q     <= wdata_d;
            op_write_q  <= op_write_d;
            buf_q       <= buf_d;
        end
    end

endmodule

// File: tb/tb_icache_mem_bridge.sv
// Self-checking bench: directed vector table, reset/stray sequences and randomized traffic
// against a memory model that answers every granted word with addr ^ 0xA5A5A5A5.
module tb_icache_mem_bridge;

    localparam int unsigned AddrW  = 32;
    localparam int unsigned Lw     = 4;
    localparam int unsigned LineAw = AddrW - $clog2(Lw) - 2;
    localparam int unsigned DataW  = 32 * Lw;
    localparam int unsigned ByteW  = 4 * Lw;
    localparam logic [31:0] Key    = 32'hA5A5A5A5;

    typedef struct {
        bit                wr;
        logic [LineAw-1:0] line;
        logic [ByteW-1:0]  be;
        logic [DataW-1:0]  wd;
        int                stall_idx;
        int                stall_n;
        bit                hold;
        int                exp_vlat;
        int                exp_ilat;
    } vec_t;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } pend_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mem_req, mem_we;
    logic [AddrW-1:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_gnt, mem_rvalid;
    logic [31:0] mem_rdata;

    always #5 clk = ~clk;

    icache_mem_bridge_if #(.ADDR_W(AddrW), .LINE_WORDS(Lw)) cif ();

    icache_mem_bridge #(.ADDR_W(AddrW), .LINE_WORDS(Lw)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cache      (cif.slave),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_be     (mem_be),
        .mem_wdata  (mem_wdata),
        .mem_gnt    (mem_gnt),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata)
    );

    // A cache must never present read and write together.
    always @(posedge clk) begin
        if (rst_n && !cif.o_m_waitrequest && cif.i_m_read)
            assert (!cif.i_m_write) else $error("read and write asserted together");
    end

    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;
    pend_t       pend_q[$];
    int          gnt_mode = 0;   // 0 always, 1 random, 2 never
    bit          rsp_rand = 0;
    int          rsp_delay = 1;
    bit          stray_mode = 0;
    bit          tracking = 0;
    vec_t        cur;
    int          nreq = 0;
    int          stall_left = 0;
    logic [DataW-1:0] last_line = '0;

    function automatic logic [31:0] word_addr(input logic [LineAw-1:0] line, input int i);
        return 32'(line) * (Lw * 4) + 32'(i * 4);
    endfunction

    function automatic logic [DataW-1:0] exp_line(input logic [LineAw-1:0] line);
        logic [DataW-1:0] l;
        l = '0;
        for (int i = 0; i < Lw; i++) l[i*32 +: 32] = word_addr(line, i) ^ Key;
        return l;
    endfunction

    task automatic check(input string name, input logic [DataW-1:0] act,
                         input logic [DataW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail(input string name, input string detail);
        n_checks++;
        n_errors++;
        $display("FAIL %s: %s", name, detail);
    endtask

    // One clock: at the falling edge observe the DUT, then drive the memory side for the next
    // rising edge and log any handshake that edge will complete.
    task automatic cycle();
        logic [68:0] act_req, exp_req;
        @(negedge clk);
        cyc++;
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        if (stray_mode) begin
            mem_rvalid = 1'b1;
            mem_rdata  = 32'hFFFFFFFF;
        end else if (pend_q.size() > 0 && pend_q[0].due <= cyc &&
                     (!rsp_rand || $urandom_range(0, 2) != 0)) begin
            mem_rvalid = 1'b1;
            mem_rdata  = pend_q[0].addr ^ Key;
            void'(pend_q.pop_front());
        end
        case (gnt_mode)
            0:       mem_gnt = 1'b1;
            1:       mem_gnt = ($urandom_range(0, 1) == 1);
            default: mem_gnt = 1'b0;
        endcase
        if (mem_req && tracking && nreq == cur.stall_idx && stall_left > 0) begin
            mem_gnt = 1'b0;
            stall_left--;
        end
        if (mem_req) begin
            if (!tracking || nreq >= Lw) begin
                fail("req_unexpected", $sformatf("addr %h at cycle %0d", mem_addr, cyc));
            end else begin
                act_req = {mem_addr, mem_we, mem_be, mem_wdata};
                exp_req = {word_addr(cur.line, nreq), cur.wr, cur.be[nreq*4 +: 4],
                           cur.wd[nreq*32 +: 32]};
                check($sformatf("req_word%0d", nreq), DataW'(act_req), DataW'(exp_req));
            end
            if (mem_gnt) begin
                pend_q.push_back('{mem_addr,
                                   cyc + (rsp_rand ? int'($urandom_range(1, 3)) : rsp_delay)});
                nreq++;
            end
        end
    endtask

    // Called at a falling edge with the DUT idle; returns at the falling edge where it is idle.
    task automatic run_cmd(input vec_t v, input string tag);
        int a, vlat, ilat, nval;
        logic [DataW-1:0] seen;
        bit done;
        check({tag, "_idle_before"}, DataW'(cif.o_m_waitrequest), DataW'(0));
        cif.i_m_addr      = v.line;
        cif.i_m_byte_en   = v.be;
        cif.i_m_writedata = v.wd;
        cif.i_m_read      = !v.wr;
        cif.i_m_write     = v.wr;
        cur        = v;
        nreq       = 0;
        tracking   = 1;
        stall_left = v.stall_n;
        a = cyc; vlat = -1; ilat = -1; nval = 0; seen = '0; done = 0;
        for (int k = 0; k < 200 && !done; k++) begin
            cycle();
            if (!v.hold) begin
                cif.i_m_read  = 1'b0;
                cif.i_m_write = 1'b0;
            end
            if (cif.o_m_readdata_valid) begin
                nval++;
                vlat = cyc - a;
                seen = cif.o_m_readdata;
            end
            if (!cif.o_m_waitrequest) begin
                ilat = cyc - a;
                done = 1;
            end
        end
        tracking = 0;
        if (!done) fail({tag, "_timeout"}, "waitrequest never returned low");
        check({tag, "_req_count"}, DataW'(nreq), DataW'(Lw));
        check({tag, "_valid_count"}, DataW'(nval), DataW'(v.wr ? 0 : 1));
        if (!v.wr) begin
            check({tag, "_line"}, seen, exp_line(v.line));
            last_line = exp_line(v.line);
        end else begin
            check({tag, "_line_hold"}, cif.o_m_readdata, last_line);
        end
        if (v.exp_vlat >= 0) check({tag, "_valid_lat"}, DataW'(vlat), DataW'(v.exp_vlat));
        if (v.exp_ilat >= 0) check({tag, "_idle_lat"}, DataW'(ilat), DataW'(v.exp_ilat));
    endtask

    function automatic vec_t mk(input bit wr, input logic [LineAw-1:0] line,
                                input logic [ByteW-1:0] be, input logic [DataW-1:0] wd,
                                input int sidx, input int sn, input bit hold,
                                input int vlat, input int ilat);
        vec_t v;
        v.wr = wr; v.line = line; v.be = be; v.wd = wd;
        v.stall_idx = sidx; v.stall_n = sn; v.hold = hold;
        v.exp_vlat = vlat; v.exp_ilat = ilat;
        return v;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[8];
        vec_t v;
        logic [DataW-1:0] wd_a;
        wd_a = {32'h0, 32'h0, 32'hDEADBEEF, 32'h0};
        vecs[0] = mk(0, 28'h0000010, '0, '0, -1, 0, 0, 6, 7);
        vecs[1] = mk(0, 28'h0000010, '0, '0, 2, 3, 0, 9, 10);
        vecs[2] = mk(1, 28'h0000020, 16'h00F0, wd_a, -1, 0, 0, -1, 7);
        vecs[3] = mk(0, 28'h0000030, 16'h1234, 128'h55, -1, 0, 1, 6, 7);
        vecs[4] = mk(0, 28'h0000031, '0, '0, -1, 0, 0, 6, 7);
        vecs[5] = mk(1, 28'hFFFFFFF, '0, 128'h0123456789ABCDEF_FEDCBA9876543210, -1, 0, 0, -1, 7);
        vecs[6] = mk(0, 28'hFFFFFFF, '0, '0, 0, 1, 0, 7, 8);
        vecs[7] = mk(1, 28'h0000021, 16'hFFFF, 128'hA, 3, 2, 0, -1, 9);

        cif.i_m_addr = '0; cif.i_m_byte_en = '0; cif.i_m_writedata = '0;
        cif.i_m_read = 1'b0; cif.i_m_write = 1'b0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;

        #1;
        check("rst_waitrequest", DataW'(cif.o_m_waitrequest), DataW'(0));
        check("rst_mem_req", DataW'({mem_req, mem_we, mem_be, mem_addr}), DataW'(0));
        check("rst_valid", DataW'(cif.o_m_readdata_valid), DataW'(0));
        check("rst_readdata", cif.o_m_readdata, DataW'(0));
        @(negedge clk);
        rst_n = 1'b1;
        cycle();

        foreach (vecs[i]) begin
            gnt_mode = 0; rsp_rand = 0; rsp_delay = 1;
            run_cmd(vecs[i], $sformatf("vec%0d", i));
        end

        // Strays in IDLE must not disturb counters or the held line.
        stray_mode = 1;
        repeat (3) begin
            cycle();
            check("stray_wait", DataW'({cif.o_m_waitrequest, mem_req}), DataW'(0));
            check("stray_readdata", cif.o_m_readdata, last_line);
        end
        stray_mode = 0;
        cycle();
        run_cmd(mk(0, 28'h0000040, '0, '0, -1, 0, 0, 6, 7), "after_stray");

        // Reset after two grants, with two responses still in flight.
        rsp_delay = 3;
        cif.i_m_addr = 28'h0000050;
        cif.i_m_read = 1'b1;
        cur = mk(0, 28'h0000050, '0, '0, -1, 0, 0, -1, -1);
        cif.i_m_byte_en = '0; cif.i_m_writedata = '0;
        nreq = 0; tracking = 1; stall_left = 0;
        for (int k = 0; k < 20 && nreq < 2; k++) begin
            cycle();
            cif.i_m_read = 1'b0;
        end
        gnt_mode = 2;
        cycle();
        #2 rst_n = 1'b0;
        #1;
        check("midrst_mem_req", DataW'(mem_req), DataW'(0));
        check("midrst_wait", DataW'(cif.o_m_waitrequest), DataW'(0));
        check("midrst_valid", DataW'(cif.o_m_readdata_valid), DataW'(0));
        check("midrst_readdata", cif.o_m_readdata, DataW'(0));
        #1 rst_n = 1'b1;
        tracking = 0; gnt_mode = 0;
        repeat (4) begin
            cycle();
            check("late_rsp_state", DataW'({cif.o_m_waitrequest, cif.o_m_readdata_valid, mem_req}),
                  DataW'(0));
            check("late_rsp_readdata", cif.o_m_readdata, DataW'(0));
        end
        check("late_rsp_drained", DataW'(pend_q.size()), DataW'(0));
        rsp_delay = 1;
        last_line = '0;
        run_cmd(mk(0, 28'h0000050, '0, '0, -1, 0, 0, 6, 7), "after_reset");

        // Randomized traffic with random grant gaps and response delays.
        gnt_mode = 1; rsp_rand = 1;
        for (int i = 0; i < 24; i++) begin
            v = mk($urandom_range(0, 1), LineAw'($urandom), ByteW'($urandom),
                   {$urandom, $urandom, $urandom, $urandom}, -1, 0, 0, -1, -1);
            run_cmd(v, $sformatf("rnd%0d", i));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
